booth_algorithm: RTL and testbench
==================================

Name: booth_algorithm

Overview:
- Sequential radix-2 Booth multiplier for two signed two's-complement operands, producing a full-width signed product.
- Used as a compact arithmetic unit wherever a small signed multiply is acceptable at one partial-product step per clock.
- Operands are captured on a start strobe. One add/subtract-and-shift iteration is performed per cycle. The product is held until the next operation.

Parameters:
- WIDTH, 4, operand width in bits. Legal values are 2 to 32. The product is 2*WIDTH bits wide.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a multiply. Sampled only in IDLE.
- Q, input, WIDTH, signed multiplier. Sampled on the accepted start edge.
- M, input, WIDTH, signed multiplicand. Sampled on the accepted start edge.
- result, output, 2*WIDTH, signed product. Registered.
- busy, output, 1, high while an operation is in progress.
- done, output, 1, one-cycle pulse when result is updated.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, result=0, busy=0, done=0. All internal registers are cleared.
- States: IDLE, RUN, FINISH.
- IDLE: on a clk edge with start=1, perform the following loads and go to RUN with busy=1:
  - accumulator A (WIDTH+1 bits) = 0
  - QR = Q
  - q_m1 = 0
  - MR = sign-extended M (WIDTH+1 bits)
  - count = WIDTH
- RUN: each edge, inspect {QR[0], q_m1}:
  - 01: A = A + MR.
  - 10: A = A - MR.
  - 00 or 11: A is unchanged.
  - Then arithmetic-shift {A, QR, q_m1} right by one, with A's MSB replicated.
  - Decrement count. When the edge completing the WIDTH-th iteration occurs, go to FINISH.
- FINISH: on one edge, load result = {A[WIDTH-1:0], QR}, pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
- Latency: with start accepted at edge 0, iterations occur on edges 1..WIDTH. result and done update on edge WIDTH+1. done is high during the cycle following that edge.
- A is WIDTH+1 bits wide so that subtracting the most-negative multiplicand (-2^(WIDTH-1)) cannot overflow. The product is exact for all operand pairs, including -8 * -8 = +64 at WIDTH=4.
- result holds its last value through IDLE and RUN. It changes only in FINISH or on reset.
- start while busy=1 is ignored. It is neither queued nor allowed to corrupt the operation in progress.
- Q and M may change freely after the accepted start edge without affecting the operation.
- start held high continuously: a new operation is accepted on the first IDLE edge after FINISH, giving back-to-back operations every WIDTH+2 cycles.
- Reset asserted mid-operation aborts immediately to the reset values. No done pulse is produced.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, RUN, FINISH.
  - a default-width constant of 4.
  - a product-width function returning 2*WIDTH.
- One natural sub-module, booth_step: a combinational block that takes {A, QR, q_m1} and MR and returns the next {A, QR, q_m1}, i.e. one add/sub plus arithmetic shift.
- The top level holds the FSM, the counter and the registers.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> result=0, busy=0, done=0 immediately. No done pulse after release.
- Sign combinations (WIDTH=4), one start per pair, wait for done -> expected results:
  - Q=3, M=7 -> 21
  - Q=-3, M=7 -> -21
  - Q=3, M=-7 -> -21
  - Q=-3, M=-7 -> 21
- Second set (WIDTH=4), one start per pair, wait for done -> expected results:
  - Q=5, M=6 -> 30
  - Q=-5, M=6 -> -30
  - Q=5, M=-6 -> -30
  - Q=-5, M=-6 -> 30
- Extremes:
  - Q=-8, M=-8 -> 64 (8'b0100_0000)
  - Q=-8, M=7 -> -56
  - Q=0, M=-8 -> 0
  - Q=7, M=7 -> 49
  - Exhaustive sweep of all 256 operand pairs against a reference product.
- Timing: start pulsed at edge 0 -> busy high on edges 1..WIDTH, done high for exactly one cycle after edge WIDTH+1, result stable afterwards.
- Protocol: pulse start with new operands while busy -> ignored, and the original product is delivered. Change Q/M after the accepted start -> no effect. Hold start high -> back-to-back products every WIDTH+2 cycles.

Source files
------------

// File: rtl/booth_algorithm_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
//   state_e        - control FSM states (IDLE, RUN, FINISH)
//   DEFAULT_WIDTH  - default operand width
//   product_width  - width of the signed product for a given operand width
package booth_algorithm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;

    function automatic int unsigned product_width(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/booth_algorithm_booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   a_i   [WIDTH:0]   accumulator (one guard bit above the operand width)
//   qr_i  [WIDTH-1:0] multiplier shift register
//   qm1_i             bit shifted out of qr on the previous iteration
//   mr_i  [WIDTH:0]   sign-extended multiplicand
//   a_o, qr_o, qm1_o  next {A, QR, q_m1} after add/sub and arithmetic right shift
module booth_step
    import booth_algorithm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] qr_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   mr_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] qr_o,
    output logic             qm1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = a_i;
        unique case ({qr_i[0], qm1_i})
            2'b01:   sum = a_i + mr_i;
            2'b10:   sum = a_i - mr_i;
            default: sum = a_i;
        endcase
    end

    // Arithmetic shift of the concatenation {sum, qr, q_m1} right by one.
    assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
    assign qr_o  = {sum[0], qr_i[WIDTH-1:1]};
    assign qm1_o = qr_i[0];

endmodule

// File: rtl/booth_algorithm.sv
// Sequential radix-2 Booth multiplier, one add/sub-and-shift step per clock.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   begin a multiply (only honoured in IDLE)
//   Q       signed multiplier, captured on the accepted start edge
//   M       signed multiplicand, captured on the accepted start edge
//   result  registered signed product, 2*WIDTH bits, held until the next FINISH
//   busy    high while an operation is in progress
//   done    one-cycle pulse when result has just been updated
module booth_algorithm
    import booth_algorithm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [WIDTH-1:0]                  Q,
    input  logic [WIDTH-1:0]                  M,
    output logic [product_width(WIDTH)-1:0]   result,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned PW   = product_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   mr_q, mr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PW-1:0]    result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_qr;
    logic             step_qm1;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_booth_step (
        .a_i   (a_q),
        .qr_i  (qr_q),
        .qm1_i (qm1_q),
        .mr_i  (mr_q),
        .a_o   (step_a),
        .qr_o  (step_qr),
        .qm1_o (step_qm1)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        qr_d     = qr_q;
        qm1_d    = qm1_q;
        mr_d     = mr_q;
        count_d  = count_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    qr_d    = Q;
                    qm1_d   = 1'b0;
                    // Guard bit keeps A - MR exact for the most-negative multiplicand.
                    mr_d    = {M[WIDTH-1], M};
                    count_d = CntW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = step_a;
                qr_d    = step_qr;
                qm1_d   = step_qm1;
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d = {a_q[WIDTH-1:0], qr_q};
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            qr_q     <= '0;
            qm1_q    <= 1'b0;
            mr_q     <= '0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            qr_q     <= qr_d;
            qm1_q    <= qm1_d;
            mr_q     <= mr_d;
            count_q  <= count_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_booth_algorithm.sv
module tb_booth_algorithm;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  Q;
    logic [W-1:0]  M;
    logic [PW-1:0] result;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    booth_algorithm #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .Q      (Q),
        .M      (M),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ordinary signed integer multiplication, truncated to the product width.
    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] q, input logic [W-1:0] m);
        int p;
        p = int'($signed(q)) * int'($signed(m));
        return p[PW-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One multiply. Operands are scrambled after the accept edge; optionally a
    // foreign start is pulsed while busy, which must be ignored.
    task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] m, input bit poke,
                          input bit full_checks, input string tag);
        int cyc;
        logic [PW-1:0] exp;
        exp = ref_prod(q, m);
        @(negedge clk);
        start = 1'b1;
        Q     = q;
        M     = m;
        @(negedge clk);               // edge 0 has passed
        start = 1'b0;
        Q     = W'($urandom);
        M     = W'($urandom);
        cyc   = 1;
        if (full_checks) check({tag, " busy after start"}, busy, 1'b1);
        while (!done && cyc < 20) begin
            if (full_checks) check({tag, " busy while running"}, busy, 1'b1);
            if (poke && cyc == 2) begin
                start = 1'b1;
                Q     = W'($urandom);
                M     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        // done visible after edge W+1, i.e. W+2 edges counting edge 0
        check({tag, " latency"}, cyc, W + 2);
        check({tag, " result"}, result, exp);
        if (full_checks) begin
            check({tag, " busy at done"}, busy, 1'b0);
            @(negedge clk);
            check({tag, " done one cycle"}, done, 1'b0);
            check({tag, " result held"}, result, exp);
            check({tag, " no queued op"}, busy, 1'b0);
        end
    endtask

    initial begin
        int dones;
        int last_done;
        int gap;
        logic [W-1:0] bq;
        logic [W-1:0] bm;
        logic [PW-1:0] bexp;

        rst_n = 1'b0;
        start = 1'b0;
        Q     = '0;
        M     = '0;
        #2;
        check("reset result", result, '0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sign combinations and extremes
        run_op(4'd3,  4'd7,  1'b0, 1'b1, "3*7");
        run_op(-4'sd3, 4'd7, 1'b0, 1'b1, "-3*7");
        run_op(4'd3, -4'sd7, 1'b0, 1'b1, "3*-7");
        run_op(-4'sd3, -4'sd7, 1'b0, 1'b1, "-3*-7");
        run_op(4'd5,  4'd6,  1'b0, 1'b1, "5*6");
        run_op(-4'sd5, 4'd6, 1'b0, 1'b1, "-5*6");
        run_op(4'd5, -4'sd6, 1'b0, 1'b1, "5*-6");
        run_op(-4'sd5, -4'sd6, 1'b0, 1'b1, "-5*-6");
        run_op(4'b1000, 4'b1000, 1'b0, 1'b1, "-8*-8");
        check("-8*-8 literal", result, 8'b0100_0000);
        run_op(4'b1000, 4'd7, 1'b0, 1'b1, "-8*7");
        run_op(4'd0, 4'b1000, 1'b0, 1'b1, "0*-8");
        run_op(4'd7, 4'd7, 1'b0, 1'b1, "7*7");

        // Start pulsed while busy must be ignored
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'b1, 1'b1, "busy poke");
        end

        // Exhaustive sweep
        for (int qi = 0; qi < (1 << W); qi++) begin
            for (int mi = 0; mi < (1 << W); mi++) begin
                run_op(W'(qi), W'(mi), 1'b0, 1'b0, "sweep");
            end
        end

        // Back-to-back with start held high; new operands presented at each done
        bq = W'($urandom);
        bm = W'($urandom);
        bexp = ref_prod(bq, bm);
        @(negedge clk);
        start = 1'b1;
        Q     = bq;
        M     = bm;
        dones = 0;
        last_done = 0;
        for (int c = 1; c < 60 && dones < 4; c++) begin
            @(negedge clk);
            if (done) begin
                check("b2b result", result, bexp);
                if (dones > 0) begin
                    gap = c - last_done;
                    check("b2b interval", gap, W + 2);
                end
                last_done = c;
                dones++;
                bq = W'($urandom);
                bm = W'($urandom);
                bexp = ref_prod(bq, bm);
                Q = bq;
                M = bm;
            end
        end
        check("b2b done count", dones, 4);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Reset mid-operation
        run_op(4'd7, 4'd5, 1'b0, 1'b0, "pre-reset");
        @(negedge clk);
        start = 1'b1;
        Q     = 4'd6;
        M     = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop reset result", result, '0);
        check("midop reset busy", busy, 1'b0);
        check("midop reset done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no done after reset", dones, 0);
        check("idle after reset", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
